div_hilo_ctrl: RTL and testbench
================================

// Module: div_hilo_ctrl
// PURPOSE
//  Issue/retire controller between the EX stage and the 32-bit signed iterative divider.
//  Accepts a DIV request from EX, launches the divider and stalls EX until the result arrives.
//  Holds the architectural HI/LO registers: HI = remainder, LO = quotient.
//  Also services MTHI/MTLO writes and handles divide-by-zero, flush cancel and a watchdog.
// PARAMETERS
//  DIV_ZERO_BYPASS  1   1: divisor==0 skips the divider and writes HI=src_a, LO=32'hFFFF_FFFF.
//                       0: divisor==0 goes through the divider like any other divisor.
//  WAIT_MAX         40  maximum WAIT/DRAIN cycles before div_err is set.
// PORTS
//  clk           in   1   clock
//  resetn        in   1   asynchronous reset, active low
//  div_req       in   1   EX holds a DIV; level, held by EX while div_busy=1
//  div_cancel    in   1   flush: the in-flight or requesting DIV must not update HI/LO
//  src_a         in   32  dividend (rs)
//  src_b         in   32  divisor (rt)
//  div_dividend  out  32  to divider
//  div_divisor   out  32  to divider
//  div_A_valid   out  1   to divider, launch strobe
//  div_B_valid   out  1   to divider, same value as div_A_valid
//  div_out       in   64  from divider, {remainder, quotient}
//  div_validout  in   1   from divider, one-cycle result strobe
//  hi_we         in   1   MTHI write enable
//  lo_we         in   1   MTLO write enable
//  hi_wdata      in   32  MTHI write data
//  lo_wdata      in   32  MTLO write data
//  hi_rdata      out  32  HI register (registered)
//  lo_rdata      out  32  LO register (registered)
//  div_busy      out  1   stall to EX
//  div_done      out  1   one-cycle pulse: HI/LO are written at the end of this cycle
//  div_err       out  1   sticky watchdog error
// BEHAVIOUR
//  Reset (resetn=0, asynchronous): state=IDLE; HI=0, LO=0; div_A_valid/div_B_valid=0;
//    div_dividend=0, div_divisor=0; div_done=0; div_err=0; wait counter=0.
//  States: IDLE, ISSUE, WAIT, DRAIN.
//   IDLE: req = div_req & ~div_cancel.
//    - req with src_b!=0, or with DIV_ZERO_BYPASS=0: latch src_a/src_b into div_dividend/div_divisor; go to ISSUE.
//    - req with src_b==0 and DIV_ZERO_BYPASS=1: stay in IDLE; div_done=1 combinationally;
//      HI<=src_a and LO<=32'hFFFF_FFFF at the end of this cycle.
//    - div_req with div_cancel in the same cycle: ignored.
//   ISSUE: div_A_valid=div_B_valid=1 for exactly this cycle, unless div_cancel=1.
//    - div_cancel=1: strobes held at 0; go to IDLE.
//    - otherwise: go to WAIT; clear the wait counter.
//   WAIT: counter increments every cycle.
//    - div_validout & ~div_cancel: HI<=div_out[63:32], LO<=div_out[31:0]; div_done=1; go to IDLE.
//    - div_validout & div_cancel: result discarded; div_done=0; go to IDLE.
//    - div_cancel without div_validout: go to DRAIN. The divider cannot be aborted.
//   DRAIN: wait for div_validout, discard the result, go to IDLE. div_cancel has no effect here.
//  Watchdog: the counter reaching WAIT_MAX in WAIT or DRAIN sets div_err (sticky until reset)
//    and forces the state to IDLE.
//  div_busy = (state!=IDLE) | (req & ~(zero bypass taken)), combinational.
//    div_busy drops in the div_done cycle, so EX advances at that edge.
//  Latency, request in cycle 0: ISSUE in cycle 1 (divider samples at edge 1); div_validout and
//    div_done in cycle 34; div_busy=1 in cycles 0..33 and 0 in cycle 34; new HI/LO visible on
//    hi_rdata/lo_rdata in cycle 35.
//  MTHI/MTLO: applied at the clock edge in any state.
//    A MTHI/MTLO write at the same edge as a divide result loses; the divide result wins.
//    A MTHI/MTLO write during WAIT is overwritten when the result retires.
//  A new div_req while state!=IDLE is not accepted; EX holds it until it is accepted.
//  Reset mid-operation: the controller and the divider both return to idle and nothing retires.
// TESTING
//  1 100/7: src_a=100, src_b=7 -> div_done in cycle 34; LO=14, HI=2; div_busy low from cycle 34.
//  2 -100/7 -> LO=32'hFFFF_FFF2, HI=32'hFFFF_FFFE; 7/-2 -> LO=32'hFFFF_FFFD, HI=1.
//  3 src_a=5, src_b=0, DIV_ZERO_BYPASS=1 -> div_done in cycle 0; strobes never asserted;
//    HI=5, LO=32'hFFFF_FFFF; div_busy stays 0.
//  4 HI/LO=0x11/0x22; 9/2 issued; div_cancel in cycle 10 -> DRAIN; result 4/1 discarded;
//    HI/LO remain 0x11/0x22; div_busy falls in cycle 34.
//  5 MTLO 0xAA in IDLE -> lo_rdata=0xAA next cycle; MTHI 0x55 in WAIT -> hi_rdata=0x55
//    until retire; 9/2 then overwrites it: HI=1, LO=4.
//  6 resetn low in cycle 20 of a divide -> HI/LO=0, state IDLE; div_validout held 0 ->
//    div_err=1 after WAIT_MAX cycles.

Source files
------------

// File: rtl/div_hilo_ctrl_if.sv
// Bundle between EX/divider side (master) and the DIV issue/retire controller (slave).
interface div_hilo_ctrl_if;
  logic        div_req;
  logic        div_cancel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_A_valid;
  logic        div_B_valid;
  logic [63:0] div_out;
  logic        div_validout;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;
  logic        div_busy;
  logic        div_done;
  logic        div_err;

  modport master (
    output div_req, div_cancel, src_a, src_b, div_out, div_validout,
           hi_we, lo_we, hi_wdata, lo_wdata,
    input  div_dividend, div_divisor, div_A_valid, div_B_valid,
           hi_rdata, lo_rdata, div_busy, div_done, div_err
  );

  modport slave (
    input  div_req, div_cancel, src_a, src_b, div_out, div_validout,
           hi_we, lo_we, hi_wdata, lo_wdata,
    output div_dividend, div_divisor, div_A_valid, div_B_valid,
           hi_rdata, lo_rdata, div_busy, div_done, div_err
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// DIV issue/retire controller holding HI/LO; request to div_done is 34 cycles (0 with zero bypass).
// EX is stalled via div_busy until retire; the divider itself has no backpressure.
module div_hilo_ctrl #(
  parameter bit DIV_ZERO_BYPASS = 1'b1,
  parameter int WAIT_MAX        = 40
) (
  input logic            clk,
  input logic            resetn,
  div_hilo_ctrl_if.slave bus
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_dividend;
  logic [31:0]   r_divisor;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_err;

  logic w_req;
  logic w_bypass;
  logic w_wdog;
  logic w_launch;
  logic w_strobe;
  logic w_done;
  logic w_busy;

  assign w_req    = bus.div_req & ~bus.div_cancel;
  assign w_bypass = DIV_ZERO_BYPASS && (bus.src_b == 32'd0);
  assign w_wdog   = ((r_state == S_WAIT) || (r_state == S_DRAIN)) && (r_cnt == CW'(WAIT_MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Divider cannot be aborted: a cancel while waiting still has to drain its result.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req && !w_bypass) w_next = S_ISSUE;
      S_ISSUE: w_next = bus.div_cancel ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (bus.div_validout)    w_next = S_IDLE;
        else if (bus.div_cancel) w_next = S_DRAIN;
        else if (w_wdog)         w_next = S_IDLE;
      end
      S_DRAIN: if (bus.div_validout || w_wdog) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // busy drops in the retire cycle so EX advances on the same edge HI/LO are written.
  always_comb begin
    w_launch = 1'b0;
    w_strobe = 1'b0;
    w_done   = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_launch = w_req & ~w_bypass;
        w_done   = w_req & w_bypass;
        w_busy   = w_launch;
      end
      S_ISSUE: begin
        w_strobe = ~bus.div_cancel;
        w_busy   = 1'b1;
      end
      S_WAIT: begin
        w_done = bus.div_validout & ~bus.div_cancel;
        w_busy = ~bus.div_validout;
      end
      S_DRAIN: w_busy = ~bus.div_validout;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      if (w_launch) begin
        r_dividend <= bus.src_a;
        r_divisor  <= bus.src_b;
      end
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if ((r_state == S_WAIT) || (r_state == S_DRAIN))
        r_cnt <= r_cnt + CW'(1);
      if (w_wdog)
        r_err <= 1'b1;
      // A retiring divide takes priority over a same-edge MTHI/MTLO.
      if (w_done) begin
        if (r_state == S_IDLE) begin
          r_hi <= bus.src_a;
          r_lo <= 32'hFFFF_FFFF;
        end else begin
          r_hi <= bus.div_out[63:32];
          r_lo <= bus.div_out[31:0];
        end
      end else begin
        if (bus.hi_we) r_hi <= bus.hi_wdata;
        if (bus.lo_we) r_lo <= bus.lo_wdata;
      end
    end
  end

  assign bus.div_dividend = r_dividend;
  assign bus.div_divisor  = r_divisor;
  assign bus.div_A_valid  = w_strobe;
  assign bus.div_B_valid  = w_strobe;
  assign bus.hi_rdata     = r_hi;
  assign bus.lo_rdata     = r_lo;
  assign bus.div_busy     = w_busy;
  assign bus.div_done     = w_done;
  assign bus.div_err      = r_err;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl with a 33-cycle behavioural divider and a HI/LO scoreboard queue.
module tb_div_hilo_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_hilo_ctrl_if bus();

  div_hilo_ctrl #(.DIV_ZERO_BYPASS(1'b1), .WAIT_MAX(40)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  // Divider model: samples at the strobe edge, strobes the result 33 cycles later.
  logic        m_run;
  logic [5:0]  m_cnt;
  logic [31:0] m_a, m_b;
  logic        m_suppress = 1'b0;
  logic signed [31:0] m_q, m_r;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_run <= 1'b0;
      m_cnt <= '0;
      m_a   <= '0;
      m_b   <= '0;
    end else if (bus.div_A_valid) begin
      m_run <= 1'b1;
      m_cnt <= 6'd32;
      m_a   <= bus.div_dividend;
      m_b   <= bus.div_divisor;
    end else if (m_run) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 6'd1;
      else            m_run <= 1'b0;
    end
  end

  always_comb begin
    m_q = '1;
    m_r = m_a;
    if (m_b != 0) begin
      m_q = $signed(m_a) / $signed(m_b);
      m_r = $signed(m_a) % $signed(m_b);
    end
  end

  assign bus.div_out      = {m_r, m_q};
  assign bus.div_validout = m_run && (m_cnt == 0) && !m_suppress;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one DIV from cycle 0 until busy drops (bounded); reports timing and HI/LO one cycle later.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int cancel_cyc,
                        input int mthi_cyc, output int done_cyc, output int fall_cyc,
                        output int strobes, output logic [31:0] hi_mid, output logic [63:0] hl);
    done_cyc = -1;
    fall_cyc = -1;
    strobes  = 0;
    hi_mid   = '0;
    bus.src_a = a;
    bus.src_b = b;
    for (int cyc = 0; cyc < 80; cyc++) begin
      bus.div_req    = !(cancel_cyc >= 0 && cyc >= cancel_cyc);
      bus.div_cancel = (cyc == cancel_cyc);
      bus.hi_we      = (cyc == mthi_cyc);
      bus.hi_wdata   = 32'h55;
      @(negedge clk);
      if (bus.div_done && done_cyc < 0) done_cyc = cyc;
      if (bus.div_A_valid) strobes++;
      if (bus.div_A_valid !== bus.div_B_valid) strobes += 100;
      if (cyc == 20) hi_mid = bus.hi_rdata;
      if (!bus.div_busy && fall_cyc < 0) fall_cyc = cyc;
      tick();
      if (fall_cyc >= 0) break;
    end
    bus.div_req    = 1'b0;
    bus.div_cancel = 1'b0;
    bus.hi_we      = 1'b0;
    @(negedge clk);
    hl = {bus.hi_rdata, bus.lo_rdata};
    tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'd0) begin
      n_err++; $display("FAIL reset_hilo got %h want 0", {bus.hi_rdata, bus.lo_rdata});
    end
    n_vec++;
    if ({bus.div_busy, bus.div_done, bus.div_err, bus.div_A_valid, bus.div_B_valid} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctl got %b want 00000",
        {bus.div_busy, bus.div_done, bus.div_err, bus.div_A_valid, bus.div_B_valid});
    end
    n_vec++;
    if ({bus.div_dividend, bus.div_divisor} !== 64'd0) begin
      n_err++; $display("FAIL reset_operands got %h want 0", {bus.div_dividend, bus.div_divisor});
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_div_basic();
    int dc, fc, st;
    logic [31:0] hm;
    logic [63:0] hl, exp;
    sb.push_back({32'd2, 32'd14});
    do_div(32'd100, 32'd7, -1, -1, dc, fc, st, hm, hl);
    exp = sb.pop_front();
    n_vec++;
    if (dc !== 34) begin n_err++; $display("FAIL basic_done_cycle got %0d want 34", dc); end
    n_vec++;
    if (fc !== 34) begin n_err++; $display("FAIL basic_busy_fall got %0d want 34", fc); end
    n_vec++;
    if (st !== 1) begin n_err++; $display("FAIL basic_strobes got %0d want 1", st); end
    n_vec++;
    if (hl !== exp) begin n_err++; $display("FAIL basic_hilo got %h want %h", hl, exp); end
  endtask

  task automatic test_back_to_back();
    int dc, fc, st;
    logic [31:0] hm;
    logic [63:0] hl, exp;
    sb.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
    do_div(-32'sd100, 32'd7, -1, -1, dc, fc, st, hm, hl);
    exp = sb.pop_front();
    n_vec++;
    if (hl !== exp) begin n_err++; $display("FAIL neg_dividend got %h want %h", hl, exp); end
    sb.push_back({32'd1, 32'hFFFF_FFFD});
    do_div(32'd7, -32'sd2, -1, -1, dc, fc, st, hm, hl);
    exp = sb.pop_front();
    n_vec++;
    if (hl !== exp) begin n_err++; $display("FAIL neg_divisor got %h want %h", hl, exp); end
    n_vec++;
    if (dc !== 34) begin n_err++; $display("FAIL b2b_done_cycle got %0d want 34", dc); end
  endtask

  task automatic test_zero_bypass();
    int dc, fc, st;
    logic [31:0] hm;
    logic [63:0] hl, exp;
    sb.push_back({32'd5, 32'hFFFF_FFFF});
    do_div(32'd5, 32'd0, -1, -1, dc, fc, st, hm, hl);
    exp = sb.pop_front();
    n_vec++;
    if (dc !== 0) begin n_err++; $display("FAIL zero_done_cycle got %0d want 0", dc); end
    n_vec++;
    if (fc !== 0) begin n_err++; $display("FAIL zero_busy got %0d want 0", fc); end
    n_vec++;
    if (st !== 0) begin n_err++; $display("FAIL zero_strobes got %0d want 0", st); end
    n_vec++;
    if (hl !== exp) begin n_err++; $display("FAIL zero_hilo got %h want %h", hl, exp); end
  endtask

  task automatic test_cancel_drain();
    int dc, fc, st;
    logic [31:0] hm;
    logic [63:0] hl, exp;
    bus.hi_we = 1'b1; bus.hi_wdata = 32'h11;
    bus.lo_we = 1'b1; bus.lo_wdata = 32'h22;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    sb.push_back({32'h11, 32'h22});
    do_div(32'd9, 32'd2, 10, -1, dc, fc, st, hm, hl);
    exp = sb.pop_front();
    n_vec++;
    if (dc !== -1) begin n_err++; $display("FAIL cancel_done got %0d want -1 (none)", dc); end
    n_vec++;
    if (fc !== 34) begin n_err++; $display("FAIL cancel_busy_fall got %0d want 34", fc); end
    n_vec++;
    if (hl !== exp) begin n_err++; $display("FAIL cancel_hilo got %h want %h", hl, exp); end
  endtask

  task automatic test_mthi_mtlo();
    int dc, fc, st;
    logic [31:0] hm;
    logic [63:0] hl, exp;
    bus.lo_we = 1'b1; bus.lo_wdata = 32'hAA;
    tick();
    bus.lo_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.lo_rdata !== 32'hAA) begin
      n_err++; $display("FAIL mtlo got %h want 000000aa", bus.lo_rdata);
    end
    tick();
    sb.push_back({32'd1, 32'd4});
    do_div(32'd9, 32'd2, -1, 10, dc, fc, st, hm, hl);
    exp = sb.pop_front();
    n_vec++;
    if (hm !== 32'h55) begin n_err++; $display("FAIL mthi_in_wait got %h want 00000055", hm); end
    n_vec++;
    if (hl !== exp) begin n_err++; $display("FAIL mthi_overwritten got %h want %h", hl, exp); end
  endtask

  task automatic test_reset_watchdog();
    int err_cyc, seen;
    bus.src_a = 32'd9; bus.src_b = 32'd2; bus.div_req = 1'b1;
    repeat (20) tick();
    sb.push_back(64'd0);
    resetn = 1'b0;
    bus.div_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.hi_rdata, bus.lo_rdata} !== sb.pop_front()) begin
      n_err++; $display("FAIL midop_reset_hilo got %h want 0", {bus.hi_rdata, bus.lo_rdata});
    end
    tick();
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_done || bus.div_validout || bus.div_busy) seen++;
      tick();
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL midop_nothing_retires got %0d want 0", seen); end
    m_suppress = 1'b1;
    err_cyc = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      bus.div_req = (cyc == 0);
      @(negedge clk);
      if (bus.div_err && err_cyc < 0) err_cyc = cyc;
      tick();
    end
    n_vec++;
    if (err_cyc !== 43) begin n_err++; $display("FAIL watchdog_cycle got %0d want 43", err_cyc); end
    @(negedge clk);
    n_vec++;
    if ({bus.div_err, bus.div_busy} !== 2'b10) begin
      n_err++; $display("FAIL watchdog_sticky got %b want 10", {bus.div_err, bus.div_busy});
    end
    tick();
  endtask

  initial begin
    bus.div_req = 1'b0; bus.div_cancel = 1'b0;
    bus.src_a = '0; bus.src_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.hi_wdata = '0; bus.lo_wdata = '0;
    test_reset();
    test_div_basic();
    test_back_to_back();
    test_zero_bypass();
    test_cancel_drain();
    test_mthi_mtlo();
    test_reset_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
